// File: rtl/vp_pkg.sv
// vp_pkg: shared types and defaults for the vector processor fetch front end.
package vp_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} seq_state_t;
    localparam int PC_W_DEF = 20;
    localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = '0;
endpackage

// File: rtl/vp_sat_counter.sv
// vp_sat_counter: saturating up-counter with enable and synchronous clear.
module vp_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en && count != '1)
            count <= count + W'(1);
    end
endmodule

// File: rtl/vp_fetch_sequencer.sv
// vp_fetch_sequencer: owns the pipeline pc, handles stalls, branch redirects
// and halt draining, and keeps bring-up fetch/cycle counters.
module vp_fetch_sequencer
    import vp_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEF),
    parameter int              PIPE_DEPTH = 4,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    input  logic             halt_dec,
    output logic [PC_W-1:0]  pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int DW = $clog2(PIPE_DEPTH + 1);

    seq_state_t      state, state_nx;
    logic [PC_W-1:0] pc_nx;
    logic [DW-1:0]   drain, drain_nx;
    logic            flush_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            drain <= '0;
            flush <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            drain <= drain_nx;
            flush <= flush_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        drain_nx = drain;
        flush_nx = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nx = RUN;
                    pc_nx    = RESET_PC;
                end
            end
            RUN: begin
                if (br_taken) begin
                    pc_nx    = br_target;
                    flush_nx = 1'b1;
                end else if (halt_dec) begin
                    state_nx = DRAIN;
                    drain_nx = DW'(PIPE_DEPTH - 1);
                end else if (!stall) begin
                    pc_nx = pc + PC_W'(1);
                end
            end
            DRAIN: begin
                // A branch resolving during drain is older than the halt, so the halt is squashed.
                if (br_taken) begin
                    state_nx = RUN;
                    pc_nx    = br_target;
                    flush_nx = 1'b1;
                    drain_nx = '0;
                end else if (drain == '0) begin
                    state_nx = HALT;
                end else begin
                    drain_nx = drain - DW'(1);
                end
            end
        endcase
    end

    assign pc_valid = state == RUN;
    assign running  = state == RUN || state == DRAIN;
    assign halted   = state == HALT;

    vp_sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (state == RUN && !stall && !br_taken),
        .count (fetch_count)
    );

    vp_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (running),
        .count (cycle_count)
    );
endmodule

// File: doc/vp_fetch_sequencer.md
Name: vp_fetch_sequencer

Overview:
- Owns the program counter of the vector processor pipeline (IF/ID/EX/MEM/WB); the pipeline no longer takes pc from outside.
- Issues one fetch address per cycle and holds it on hazard stalls.
- Redirects on taken branches with a one-cycle IF/ID flush.
- On a decoded halt, drains the pipeline before reporting halted; keeps cycle and fetch counters for bring-up.

Parameters:
- PC_W, 20, program counter width, matches the processor pc bus.
- RESET_PC, 0, fetch address after reset and after start.
- PIPE_DEPTH, 4, cycles from halt decode until the last older instruction leaves WB.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  processor clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE or HALT and begin fetching at RESET_PC.
- stall  in  1  hazard unit hold request.
- br_taken  in  1  branch resolved taken in EX, one-cycle pulse.
- br_target  in  PC_W  branch destination, valid with br_taken.
- halt_dec  in  1  halt instruction decoded in ID.
- pc  out  PC_W  current fetch address.
- pc_valid  out  1  pc is a real fetch this cycle.
- flush  out  1  clear IF/ID register this cycle.
- running  out  1  state is RUN or DRAIN.
- halted  out  1  state is HALT.
- fetch_count  out  CNT_W  number of fetches accepted.
- cycle_count  out  CNT_W  cycles spent in RUN or DRAIN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, pc=RESET_PC, all counters 0.
  - pc_valid=0, flush=0, running=0, halted=0.
  - Reset wins over every other input, including mid-DRAIN.
- States are IDLE, RUN, DRAIN and HALT. All outputs are registered.
- IDLE:
  - pc_valid=0.
  - start -> RUN with pc=RESET_PC.
- RUN priority per cycle is br_taken > halt_dec > stall > advance.
  - br_taken: next pc=br_target; flush=1 next cycle; stall ignored this cycle.
  - halt_dec (no branch): -> DRAIN; pc frozen; pc_valid=0 from the next cycle; drain counter loads PIPE_DEPTH-1.
  - stall: pc holds; pc_valid stays 1; fetch_count does not increment.
  - advance: pc = pc+1, wrapping modulo 2^PC_W (0xFFFFF -> 0x00000, no error).
- pc_valid and fetch_count:
  - pc_valid=1 in every RUN cycle.
  - fetch_count increments in each RUN cycle without stall or br_taken.
  - The redirected fetch counts from the following cycle.
- DRAIN:
  - Drain counter decrements each cycle; stall does not pause it.
  - At 0 -> HALT.
  - br_taken during DRAIN means the halt was younger than the branch and is discarded: -> RUN at br_target, flush=1, drain counter cleared.
- HALT:
  - halted=1, pc frozen, pc_valid=0.
  - start -> RUN at RESET_PC, counters kept.
  - start while in RUN or DRAIN is ignored.
- cycle_count increments every cycle in RUN or DRAIN and saturates at all-ones. fetch_count also saturates.
- Simultaneous halt_dec and br_taken in RUN: the branch wins and halt_dec is dropped.
- flush is a single-cycle pulse. Back-to-back br_taken gives flush high on consecutive cycles, and the last target wins.

Decomposition:
- Package vp_pkg holds:
  - enum seq_state_t {IDLE, RUN, DRAIN, HALT};
  - localparam PC_W_DEF=20;
  - the RESET_PC default.
- One natural sub-module: vp_sat_counter (parameterised width, enable, sync clear), instantiated for fetch_count and cycle_count.

Test Plan:
- Reset then start, no other input for 5 cycles -> pc 0,1,2,3,4 with pc_valid=1; fetch_count=5.
- stall high for 3 cycles at pc=0x00010 -> pc holds 0x00010 with pc_valid=1; fetch_count unchanged; cycle_count +3.
- br_taken with br_target=0x00400 while stall=1 -> next pc=0x00400; flush=1 for exactly one cycle.
- halt_dec at pc=0x00020 with PIPE_DEPTH=4 -> DRAIN for 4 cycles, then halted=1, pc_valid=0, pc=0x00020. A later start restarts at pc=0.
- halt_dec, then br_taken to 0x00100 on the second DRAIN cycle -> back to RUN at 0x00100 with flush=1; halted never asserts.
- pc preloaded near 0xFFFFE -> advances 0xFFFFF then 0x00000. Separately, rst mid-DRAIN -> IDLE with all outputs 0 next cycle.
